// File: rtl/exercise_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : audio_trainer_pkg                                              |
// | Purpose  : Shared widths, markers, FSM state type and score helper for    |
// |            the exercise sequencer.                                        |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package audio_trainer_pkg;

    localparam int PERIOD_W = 19;
    localparam int SCORE_W  = 8;

    localparam logic [PERIOD_W-1:0] END_MARKER  = '1;
    localparam logic [PERIOD_W-1:0] REST_PERIOD = '0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PLAY = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } seq_state_t;

    // Score counters stick at full scale instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/exercise_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : exercise_sequencer_if                                          |
// | Purpose  : Control, pattern-ROM, player-pitch and score signals of the    |
// |            exercise sequencer. slave = sequencer, master = its user.      |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface exercise_sequencer_if #(
    parameter int ADDR_W = 4
) ();

    logic                                    start;
    logic                                    abort;
    logic                                    loop_en;
    logic [audio_trainer_pkg::PERIOD_W-1:0]  step_period;
    logic [audio_trainer_pkg::PERIOD_W-1:0]  player_period;
    logic [ADDR_W-1:0]                       step_addr;
    logic [audio_trainer_pkg::PERIOD_W-1:0]  tone_period;
    logic                                    busy;
    logic                                    beat_tick;
    logic                                    step_hit;
    logic                                    done;
    logic [audio_trainer_pkg::SCORE_W-1:0]   hit_count;
    logic [audio_trainer_pkg::SCORE_W-1:0]   miss_count;

    modport slave (
        input  start, abort, loop_en, step_period, player_period,
        output step_addr, tone_period, busy, beat_tick, step_hit, done,
               hit_count, miss_count
    );

    modport master (
        output start, abort, loop_en, step_period, player_period,
        input  step_addr, tone_period, busy, beat_tick, step_hit, done,
               hit_count, miss_count
    );

endinterface
`default_nettype wire

// File: rtl/exercise_sequencer_beat_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : beat_timer                                                     |
// | Purpose  : Clearable up-counter with a terminal-count flag; the terminal  |
// |            value is supplied by the caller so PLAY and GAP share it.      |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module beat_timer #(
    parameter int CNT_W = 3
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clear,
    input  wire logic [CNT_W-1:0] i_last,
    output logic                  o_tc
);

    logic [CNT_W-1:0] r_count;

    // Count up each cycle; clearing restarts the interval at 0.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == i_last);

endmodule
`default_nettype wire

// File: rtl/exercise_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : exercise_sequencer                                             |
// | Purpose  : Steps through a pattern ROM one note per beat with a silent    |
// |            gap, drives the tone generator half-period and scores the      |
// |            player's pitch at the end of each beat.                        |
// | Options  : EXERCISE_SCORE_EN - build compare logic and hit/miss scores;   |
// |            when undefined the scores and step_hit are tied to 0.          |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module exercise_sequencer
    import audio_trainer_pkg::*;
#(
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_500_000,
    parameter int NUM_STEPS   = 16
) (
    input  wire logic          CLOCK_50,
    input  wire logic          resetn,
    exercise_sequencer_if.slave bus
);

    localparam int c_ADDR_W = $clog2(NUM_STEPS);
    localparam int c_MAX_CY = (BEAT_CYCLES > GAP_CYCLES) ? BEAT_CYCLES : GAP_CYCLES;
    localparam int c_CNT_W  = $clog2(c_MAX_CY);
    localparam logic [c_CNT_W-1:0]  c_BEAT_LAST = c_CNT_W'(BEAT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]  c_GAP_LAST  = c_CNT_W'(GAP_CYCLES - 1);
    localparam logic [c_ADDR_W-1:0] c_LAST_STEP = c_ADDR_W'(NUM_STEPS - 1);

    seq_state_t            r_state;
    seq_state_t            w_next;
    logic                  w_rst;
    logic                  w_tc;
    logic                  w_timer_clear;
    logic [c_CNT_W-1:0]    w_last;
    logic                  w_start;
    logic                  w_play_end;
    logic                  w_gap_end;
    logic [PERIOD_W-1:0]   w_tone;
    logic [PERIOD_W-1:0]   r_target;
    logic [PERIOD_W-1:0]   r_tone;
    logic [c_ADDR_W-1:0]   r_step_addr;
    logic                  r_busy;
    logic                  r_beat_tick;
    logic                  r_done;

    assign w_rst = ~resetn;

    // The timer only runs through PLAY and GAP; everywhere else, and at each
    // terminal count, it is held at 0 so the next interval starts clean.
    assign w_timer_clear = !((r_state == PLAY) || (r_state == GAP)) || w_tc;
    assign w_last        = (r_state == PLAY) ? c_BEAT_LAST : c_GAP_LAST;

    beat_timer #(
        .CNT_W (c_CNT_W)
    ) u_beat_timer (
        .clk     (CLOCK_50),
        .rst     (w_rst),
        .i_clear (w_timer_clear),
        .i_last  (w_last),
        .o_tc    (w_tc)
    );

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus the qualified events the datapath acts on.
    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_play_end = 1'b0;
        w_gap_end  = 1'b0;
        w_tone     = REST_PERIOD;
        case (r_state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_start = 1'b1;
                    w_next  = LOAD;
                end
            end
            LOAD: begin
                w_next = (bus.step_period == END_MARKER) ? DONE : PLAY;
            end
            PLAY: begin
                if (w_tc) begin
                    w_play_end = !bus.abort;
                    w_next     = GAP;
                end
            end
            GAP: begin
                if (w_tc) begin
                    w_gap_end = !bus.abort;
                    w_next    = (r_step_addr == c_LAST_STEP && !bus.loop_en) ? DONE : LOAD;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        if (bus.abort) begin
            w_next = IDLE;
        end
        // Tone is registered, so it follows the state being entered; on
        // entry from LOAD the target is taken straight from the ROM.
        if (w_next == PLAY) begin
            w_tone = (r_state == LOAD) ? bus.step_period : r_target;
        end
    end

    // Step address, target note and registered status outputs.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_target    <= '0;
            r_step_addr <= '0;
            r_tone      <= '0;
            r_busy      <= 1'b0;
            r_beat_tick <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (r_state == LOAD) begin
                r_target <= bus.step_period;
            end
            if (w_start) begin
                r_step_addr <= '0;
            end else if (w_gap_end) begin
                if (r_step_addr != c_LAST_STEP) begin
                    r_step_addr <= r_step_addr + 1'b1;
                end else if (bus.loop_en) begin
                    r_step_addr <= '0;
                end
            end
            r_tone      <= w_tone;
            r_busy      <= (w_next != IDLE);
            r_beat_tick <= w_play_end;
            r_done      <= (w_next == DONE);
        end
    end

`ifdef EXERCISE_SCORE_EN
    logic               w_hit;
    logic [SCORE_W-1:0] r_hit_count;
    logic [SCORE_W-1:0] r_miss_count;
    logic               r_step_hit;

    // Plain equality also handles rests: a rest target of 0 hits only when
    // the player is silent too.
    assign w_hit = (bus.player_period == r_target);

    // Score the beat on its last PLAY cycle; a new start clears the scores.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_step_hit   <= 1'b0;
        end else begin
            r_step_hit <= w_play_end && w_hit;
            if (w_start) begin
                r_hit_count  <= '0;
                r_miss_count <= '0;
            end else if (w_play_end) begin
                if (w_hit) begin
                    r_hit_count <= sat_inc(r_hit_count);
                end else begin
                    r_miss_count <= sat_inc(r_miss_count);
                end
            end
        end
    end

    assign bus.hit_count  = r_hit_count;
    assign bus.miss_count = r_miss_count;
    assign bus.step_hit   = r_step_hit;
`else
    logic w_unused_player;

    assign w_unused_player = ^{bus.player_period, r_target};
    assign bus.hit_count   = '0;
    assign bus.miss_count  = '0;
    assign bus.step_hit    = 1'b0;
`endif

    assign bus.step_addr   = r_step_addr;
    assign bus.tone_period = r_tone;
    assign bus.busy        = r_busy;
    assign bus.beat_tick   = r_beat_tick;
    assign bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_exercise_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_exercise_sequencer                                          |
// | Purpose  : Directed self-checking bench for exercise_sequencer with       |
// |            BEAT_CYCLES=8, GAP_CYCLES=2, NUM_STEPS=4 (11-cycle steps).     |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_exercise_sequencer;

    localparam int c_BEAT  = 8;
    localparam int c_GAP   = 2;
    localparam int c_STEPS = 4;
`ifdef EXERCISE_SCORE_EN
    localparam int c_SC = 1;
`else
    localparam int c_SC = 0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic [18:0] rom [4];
    logic        match_mode;
    logic [18:0] fixed_player;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    exercise_sequencer_if #(.ADDR_W(2)) bus ();

    exercise_sequencer #(
        .BEAT_CYCLES (c_BEAT),
        .GAP_CYCLES  (c_GAP),
        .NUM_STEPS   (c_STEPS)
    ) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .bus      (bus)
    );

    assign bus.step_period   = rom[bus.step_addr];
    assign bus.player_period = match_mode ? rom[bus.step_addr] : fixed_player;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rom(input logic [18:0] a, b, c, d);
        rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
    endtask

    // Pulse start for one edge; afterwards the DUT is in LOAD of step 0.
    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run(input int n, output int done_at, output int ticks,
                       output int hits, output int wraps, output int dones);
        logic [1:0] prev;
        done_at = -1; ticks = 0; hits = 0; wraps = 0; dones = 0;
        prev = bus.step_addr;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (bus.done) begin
                dones++;
                if (done_at < 0) done_at = i;
            end
            if (bus.beat_tick) ticks++;
            if (bus.step_hit) hits++;
            if (prev == 2'd3 && bus.step_addr == 2'd0) wraps++;
            prev = bus.step_addr;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int done_at, ticks, hits, wraps, dones;

        resetn = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; bus.loop_en = 1'b0;
        match_mode = 1'b1; fixed_player = '0;
        set_rom(19'd191204, 19'd170357, 19'd0, 19'd127551);
        tick(); tick();
        check("rst_tone", bus.tone_period, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_addr", bus.step_addr, 0);
        check("rst_hit", bus.hit_count, 0);
        check("rst_miss", bus.miss_count, 0);
        check("rst_done", bus.done, 0);
        check("rst_tick", bus.beat_tick, 0);
        resetn = 1'b1;
        tick();

        // Basic run, player always matches.
        do_start();
        check("load_busy", bus.busy, 1);
        check("load_tone", bus.tone_period, 0);
        done_at = -1; ticks = 0; hits = 0;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (bus.done && done_at < 0) done_at = i;
            if (bus.beat_tick) ticks++;
            if (bus.step_hit) hits++;
            if (i == 1)  check("s0_tone", bus.tone_period, 191204);
            if (i == 9) begin
                check("s0_tick", bus.beat_tick, 1);
                check("s0_gap_tone", bus.tone_period, 0);
                check("s0_hit", bus.hit_count, c_SC);
            end
            if (i == 11) check("s1_addr", bus.step_addr, 1);
            if (i == 12) check("s1_tone", bus.tone_period, 170357);
            if (i == 23) check("s2_rest_tone", bus.tone_period, 0);
            if (i == 34) check("s3_tone", bus.tone_period, 127551);
        end
        check("basic_done_at", done_at, 44);
        check("basic_ticks", ticks, 4);
        check("basic_step_hits", hits, 4 * c_SC);
        check("basic_hit", bus.hit_count, 4 * c_SC);
        check("basic_miss", bus.miss_count, 0);
        check("basic_idle", bus.busy, 0);

        // Misses: fixed wrong pitch, rest step included.
        match_mode = 1'b0; fixed_player = 19'd95510;
        do_start();
        run(50, done_at, ticks, hits, wraps, dones);
        check("miss_done_at", done_at, 44);
        check("miss_ticks", ticks, 4);
        check("miss_step_hits", hits, 0);
        check("miss_hit", bus.hit_count, 0);
        check("miss_miss", bus.miss_count, 4 * c_SC);

        // End marker at step 1.
        match_mode = 1'b1;
        set_rom(19'd191204, 19'h7FFFF, 19'd0, 19'd0);
        do_start();
        run(20, done_at, ticks, hits, wraps, dones);
        check("end_done_at", done_at, 12);
        check("end_dones", dones, 1);
        check("end_ticks", ticks, 1);
        check("end_score", bus.hit_count + bus.miss_count, c_SC);

        // Abort in the 3rd PLAY cycle of step 1.
        set_rom(19'd191204, 19'd170357, 19'd0, 19'd127551);
        do_start();
        for (int i = 1; i <= 14; i++) tick();
        check("abort_pre_tone", bus.tone_period, 170357);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_tone", bus.tone_period, 0);
        check("abort_done", bus.done, 0);
        check("abort_addr", bus.step_addr, 1);
        check("abort_hit", bus.hit_count, c_SC);
        check("abort_miss", bus.miss_count, 0);
        run(20, done_at, ticks, hits, wraps, dones);
        check("abort_no_done", dones, 0);
        check("abort_stay_idle", bus.busy, 0);

        // start together with abort in IDLE must not start or clear anything.
        bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        check("sa_busy", bus.busy, 0);
        check("sa_addr", bus.step_addr, 1);
        check("sa_hit", bus.hit_count, c_SC);

        // Reset mid-PLAY: tone silent from the next edge.
        do_start();
        for (int i = 1; i <= 3; i++) tick();
        check("rp_tone_pre", bus.tone_period, 191204);
        resetn = 1'b0;
        tick();
        check("rp_tone", bus.tone_period, 0);
        resetn = 1'b1;
        tick();

        // Reset mid-GAP of step 1.
        do_start();
        for (int i = 1; i <= 20; i++) tick();
        check("rg_addr_pre", bus.step_addr, 1);
        resetn = 1'b0;
        tick();
        check("rg_tone", bus.tone_period, 0);
        check("rg_busy", bus.busy, 0);
        check("rg_addr", bus.step_addr, 0);
        check("rg_hit", bus.hit_count, 0);
        check("rg_miss", bus.miss_count, 0);
        check("rg_tick", bus.beat_tick, 0);
        resetn = 1'b1;
        tick();

        // Loop for 300 steps; a stray start while busy must be ignored.
        bus.loop_en = 1'b1;
        do_start();
        ticks = 0; dones = 0; wraps = 0;
        begin
            logic [1:0] prev;
            prev = bus.step_addr;
            for (int i = 1; i <= 300 * 11; i++) begin
                tick();
                if (bus.done) dones++;
                if (bus.beat_tick) ticks++;
                if (prev == 2'd3 && bus.step_addr == 2'd0) wraps++;
                prev = bus.step_addr;
                if (i == 2802) check("sat_pre", bus.hit_count, 254 * c_SC);
                bus.start = (i == 100);
            end
        end
        check("loop_ticks", ticks, 300);
        check("loop_wraps", wraps, 75);
        check("loop_no_done", dones, 0);
        check("loop_hit_sat", bus.hit_count, 255 * c_SC);
        check("loop_miss", bus.miss_count, 0);
        check("loop_busy", bus.busy, 1);
        check("loop_addr", bus.step_addr, 0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("loop_abort_idle", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
